dmem_ctrl: RTL and testbench

DMEM_CTRL -- requirements
Module: dmem_ctrl

---
 rtl/dmem_pkg.sv | 13 +
 rtl/dmem_if.sv | 24 ++
 rtl/dmem_ram.sv | 31 +++
 rtl/dmem_ctrl.sv | 145 ++++++++++++++
 tb/tb_dmem_ctrl.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory controller and its RAM.
package dmem_pkg;

  localparam int unsigned DATA_W         = 32;
  localparam int unsigned BE_W           = DATA_W / 8;
  localparam int unsigned DEPTH_LOG2_DEF = 10;

  typedef enum logic {
    CLEAR,
    READY
  } state_e;

endpackage

// File: rtl/dmem_if.sv
// Core-side data-memory bus: request/address/data from the core, load data and status back.
interface dmem_if;
  import dmem_pkg::*;

  logic              dce;
  logic [31:0]       daddr;
  logic [BE_W-1:0]   we;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dm;
  logic              ready;
  logic              err;
  logic [7:0]        err_cnt;

  modport master (
    output dce, daddr, we, din,
    input  dm, ready, err, err_cnt
  );

  modport slave (
    input  dce, daddr, we, din,
    output dm, ready, err, err_cnt
  );

endinterface

// File: rtl/dmem_ram.sv
// Single-port synchronous RAM with byte-lane write enables; read data register holds when idle.
module dmem_ram
  import dmem_pkg::*;
#(
  parameter int unsigned AddrW = DEPTH_LOG2_DEF
) (
  input  logic              clk_i,
  input  logic [AddrW-1:0]  addr_i,
  input  logic [BE_W-1:0]   be_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**AddrW];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < BE_W; i++) begin
      if (be_i[i]) begin
        mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: clears the RAM after reset, then serves byte-masked loads/stores.
// Optional bounds checking is enabled by defining DMEM_BOUNDS_CHK_EN.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEF,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input logic   clk,
  input logic   rst_n,
  dmem_if.slave bus
);

  localparam int unsigned   AW       = DEPTH_LOG2;
  localparam logic [AW-1:0] CLR_LAST = {AW{1'b1}};

  state_e            state_q, state_d;
  logic [AW-1:0]     clr_cnt_q, clr_cnt_d;
  logic              dm_zero_q, dm_zero_d;

  logic [31:0]       offset;
  logic [AW-1:0]     word_idx;
  logic              oob;
  logic              acc, rd_ok, wr_ok;
  logic              unused_offset;

  logic [AW-1:0]     ram_addr;
  logic [BE_W-1:0]   ram_be;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_re;
  logic [DATA_W-1:0] ram_rdata;

  assign offset   = bus.daddr - BASE_ADDR;
  assign word_idx = offset[AW+1:2];
  // No access is honoured in the reset cycle, even if the FSM still reads READY.
  assign acc      = !rst_n && (state_q == READY) && bus.dce;
  assign rd_ok    = acc && (bus.we == '0) && !oob;
  assign wr_ok    = acc && (bus.we != '0) && !oob;

`ifdef DMEM_BOUNDS_CHK_EN
  logic       err_q;
  logic [7:0] err_cnt_q, err_cnt_d;

  assign oob           = |offset[DATA_W-1:AW+2];
  assign unused_offset = ^offset[1:0];
  assign err_cnt_d     = (acc && oob && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      err_q     <= acc && oob;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.err     = err_q;
  assign bus.err_cnt = err_cnt_q;
`else
  assign oob           = 1'b0;
  assign unused_offset = ^{offset[DATA_W-1:AW+2], offset[1:0]};
  assign bus.err       = 1'b0;
  assign bus.err_cnt   = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    unique case (state_q)
      CLEAR: begin
        clr_cnt_d = clr_cnt_q + AW'(1);
        if (clr_cnt_q == CLR_LAST) begin
          state_d = READY;
        end
      end
      READY:   ;
      default: state_d = CLEAR;
    endcase
  end

  // Clear sweep owns the RAM port in CLEAR; the core owns it in READY.
  always_comb begin
    bus.ready = 1'b0;
    ram_addr  = word_idx;
    ram_be    = '0;
    ram_wdata = bus.din;
    ram_re    = 1'b0;
    unique case (state_q)
      CLEAR: begin
        ram_addr  = clr_cnt_q;
        ram_be    = '1;
        ram_wdata = '0;
      end
      READY: begin
        bus.ready = 1'b1;
        ram_be    = wr_ok ? bus.we : '0;
        ram_re    = rd_ok;
      end
      default: ;
    endcase
  end

  // dm reads as zero after reset or a suppressed load, until the next real load.
  always_comb begin
    dm_zero_d = dm_zero_q;
    if (rd_ok) begin
      dm_zero_d = 1'b0;
    end else if (acc && oob && (bus.we == '0)) begin
      dm_zero_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      dm_zero_q <= 1'b1;
    end else begin
      dm_zero_q <= dm_zero_d;
    end
  end

  assign bus.dm = dm_zero_q ? '0 : ram_rdata;

  dmem_ram #(
    .AddrW (AW)
  ) u_ram (
    .clk_i   (clk),
    .addr_i  (ram_addr),
    .be_i    (ram_be),
    .wdata_i (ram_wdata),
    .re_i    (ram_re),
    .rdata_o (ram_rdata)
  );

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: reference memory model plus a queue of expected load data.
module tb_dmem_ctrl;
  import dmem_pkg::*;

  localparam int unsigned WORDS = 1024;

  typedef struct {
    logic        c;
    logic [3:0]  w;
    logic [31:0] a;
    logic [31:0] d;
  } op_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dmem_if bus ();

  dmem_ctrl #(
    .DEPTH_LOG2 (10),
    .BASE_ADDR  (32'h0000_0000)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          total = 0;
  int          bad = 0;
  logic [31:0] model_mem [WORDS];
  logic [31:0] sb_q [$];
  logic [31:0] dm_held;
  logic        model_ready;
  logic        err_pend;
  int          err_cnt_model;

  task automatic model_reset();
    for (int i = 0; i < int'(WORDS); i++) model_mem[i] = 32'h0;
    sb_q.delete();
    dm_held       = 32'h0;
    err_pend      = 1'b0;
    err_cnt_model = 0;
    model_ready   = 1'b0;
  endtask

  // Drives one cycle of stimulus and records what the DUT should do with it.
  task automatic drive(input logic c, input logic [3:0] w, input logic [31:0] a,
                       input logic [31:0] d);
    logic [9:0] idx;
    logic       oob;
    bus.dce   = c;
    bus.we    = w;
    bus.daddr = a;
    bus.din   = d;
    idx       = a[11:2];
`ifdef DMEM_BOUNDS_CHK_EN
    oob = (a >= 32'h0000_1000);
`else
    oob = 1'b0;
`endif
    err_pend = 1'b0;
    if (c && model_ready) begin
      if (oob) begin
        err_pend = 1'b1;
        if (err_cnt_model < 255) err_cnt_model++;
        if (w == 4'h0) sb_q.push_back(32'h0);
      end else if (w == 4'h0) begin
        sb_q.push_back(model_mem[idx]);
      end else begin
        for (int i = 0; i < 4; i++) if (w[i]) model_mem[idx][8*i +: 8] = d[8*i +: 8];
      end
    end
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (n < 2000) begin
      @(negedge clk);
      n++;
      if (bus.ready === 1'b1) break;
    end
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b1;
    drive(1'b0, 4'h0, 32'h0, 32'h0);
    model_reset();
    repeat (3) @(negedge clk);
    total++; if (bus.ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b want 0", bus.ready); end
    total++; if (bus.dm !== 32'h0) begin bad++; $display("FAIL rst_dm: got %h want 0", bus.dm); end
    total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", bus.err); end
    total++; if (bus.err_cnt !== 8'h0) begin bad++; $display("FAIL rst_err_cnt: got %h want 0", bus.err_cnt); end
    rst_n = 1'b0;
    wait_ready(n);
    total++; if (n !== 1024) begin bad++; $display("FAIL clear_len: got %0d want 1024", n); end
    model_ready = 1'b1;
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      if (sb_q.size() != 0) dm_held = sb_q.pop_front();
      total++;
      if (bus.dm !== dm_held) begin bad++; $display("FAIL rd_zero[%0d]: got %h want %h", i, bus.dm, dm_held); end
      if (i < 4) drive(1'b1, 4'h0, 32'(i * 404 + 3), 32'h0);
      else drive(1'b0, 4'h0, 32'h0, 32'h0);
    end
  endtask

  task automatic test_write_read();
    op_t ops [$];
    ops.push_back('{1'b1, 4'hF, 32'h10, 32'hDEADBEEF});
    ops.push_back('{1'b1, 4'h0, 32'h10, 32'h0});
    ops.push_back('{1'b0, 4'h0, 32'h0, 32'h0});
    ops.push_back('{1'b1, 4'hF, 32'h14, 32'h01234567});
    ops.push_back('{1'b0, 4'h0, 32'h0, 32'h0});
    ops.push_back('{1'b1, 4'h0, 32'h17, 32'h0});
    ops.push_back('{1'b1, 4'h0, 32'h12, 32'h0});
    for (int i = 0; i <= ops.size(); i++) begin
      @(negedge clk);
      if (sb_q.size() != 0) dm_held = sb_q.pop_front();
      total++;
      if (bus.dm !== dm_held) begin bad++; $display("FAIL wr_rd[%0d]: got %h want %h", i, bus.dm, dm_held); end
      if (i < ops.size()) drive(ops[i].c, ops[i].w, ops[i].a, ops[i].d);
      else drive(1'b0, 4'h0, 32'h0, 32'h0);
    end
  endtask

  task automatic test_byte_lanes();
    op_t ops [$];
    logic [31:0] a;
    ops.push_back('{1'b1, 4'b0010, 32'h10, 32'h0000AA00});
    ops.push_back('{1'b1, 4'h0, 32'h10, 32'h0});
    for (int k = 0; k < 20; k++) begin
      a = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      ops.push_back('{1'b1, 4'($urandom_range(1, 15)), a, $urandom});
      ops.push_back('{1'b1, 4'h0, a, 32'h0});
    end
    for (int i = 0; i <= ops.size(); i++) begin
      @(negedge clk);
      if (sb_q.size() != 0) dm_held = sb_q.pop_front();
      total++;
      if (bus.dm !== dm_held) begin bad++; $display("FAIL lanes[%0d]: got %h want %h", i, bus.dm, dm_held); end
      if (i < ops.size()) drive(ops[i].c, ops[i].w, ops[i].a, ops[i].d);
      else drive(1'b0, 4'h0, 32'h0, 32'h0);
    end
  endtask

  task automatic test_back_to_back();
    op_t ops [$];
    ops.push_back('{1'b1, 4'hF, 32'h40, 32'h11112222});
    ops.push_back('{1'b1, 4'h0, 32'h40, 32'h0});
    ops.push_back('{1'b1, 4'hF, 32'h44, 32'h33334444});
    ops.push_back('{1'b1, 4'h0, 32'h44, 32'h0});
    ops.push_back('{1'b1, 4'h0, 32'h40, 32'h0});
    ops.push_back('{1'b1, 4'h0, 32'h44, 32'h0});
    ops.push_back('{1'b0, 4'hF, 32'h40, 32'hFFFFFFFF});
    ops.push_back('{1'b1, 4'h0, 32'h40, 32'h0});
    ops.push_back('{1'b1, 4'b1001, 32'h44, 32'hA5A5A5A5});
    ops.push_back('{1'b1, 4'h0, 32'h44, 32'h0});
    for (int i = 0; i <= ops.size(); i++) begin
      @(negedge clk);
      if (sb_q.size() != 0) dm_held = sb_q.pop_front();
      total++;
      if (bus.dm !== dm_held) begin bad++; $display("FAIL b2b[%0d]: got %h want %h", i, bus.dm, dm_held); end
      if (i < ops.size()) drive(ops[i].c, ops[i].w, ops[i].a, ops[i].d);
      else drive(1'b0, 4'h0, 32'h0, 32'h0);
    end
  endtask

  task automatic test_bounds();
    op_t ops [$];
`ifdef DMEM_BOUNDS_CHK_EN
    ops.push_back('{1'b1, 4'h0, 32'h10, 32'h0});
    ops.push_back('{1'b1, 4'h0, 32'h1000, 32'h0});
    ops.push_back('{1'b0, 4'h0, 32'h0, 32'h0});
    ops.push_back('{1'b1, 4'hF, 32'h1000, 32'hFFFFFFFF});
    ops.push_back('{1'b1, 4'h0, 32'h0, 32'h0});
    ops.push_back('{1'b1, 4'h0, 32'hFFC, 32'h0});
    for (int k = 0; k < 300; k++) ops.push_back('{1'b1, 4'h0, 32'h1000 + 32'(4 * k), 32'h0});
`else
    ops.push_back('{1'b1, 4'hF, 32'h1000, 32'h12345678});
    ops.push_back('{1'b1, 4'h0, 32'h0, 32'h0});
    ops.push_back('{1'b1, 4'hF, 32'hFFFF_1014, 32'h0BADF00D});
    ops.push_back('{1'b1, 4'h0, 32'h14, 32'h0});
`endif
    for (int i = 0; i <= ops.size(); i++) begin
      @(negedge clk);
      if (sb_q.size() != 0) dm_held = sb_q.pop_front();
      total++;
      if (bus.dm !== dm_held) begin bad++; $display("FAIL bnd_dm[%0d]: got %h want %h", i, bus.dm, dm_held); end
      total++;
      if (bus.err !== err_pend) begin bad++; $display("FAIL bnd_err[%0d]: got %b want %b", i, bus.err, err_pend); end
      total++;
      if (bus.err_cnt !== 8'(err_cnt_model)) begin
        bad++; $display("FAIL bnd_cnt[%0d]: got %h want %h", i, bus.err_cnt, 8'(err_cnt_model));
      end
      if (i < ops.size()) drive(ops[i].c, ops[i].w, ops[i].a, ops[i].d);
      else drive(1'b0, 4'h0, 32'h0, 32'h0);
    end
`ifdef DMEM_BOUNDS_CHK_EN
    total++; if (bus.err_cnt !== 8'hFF) begin bad++; $display("FAIL err_sat: got %h want ff", bus.err_cnt); end
`else
    total++; if (bus.err_cnt !== 8'h00) begin bad++; $display("FAIL err_off: got %h want 00", bus.err_cnt); end
`endif
  endtask

  task automatic test_reset_mid_clear();
    int n;
    // Put data in RAM, then reset from READY; it must be gone after the re-clear.
    @(negedge clk);
    drive(1'b1, 4'hF, 32'h20, 32'hCAFEF00D);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 4'h0, 32'h20, 32'h0);
    model_reset();
    @(negedge clk);
    total++; if (bus.ready !== 1'b0) begin bad++; $display("FAIL rdy_rst_ready: got %b want 0", bus.ready); end
    total++; if (bus.dm !== 32'h0) begin bad++; $display("FAIL rdy_rst_dm: got %h want 0", bus.dm); end
    rst_n = 1'b0;
    drive(1'b0, 4'h0, 32'h0, 32'h0);
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      total++;
      if (bus.dm !== 32'h0 || bus.ready !== 1'b0) begin
        bad++; $display("FAIL clr_quiet[%0d]: dm=%h ready=%b want 0/0", i, bus.dm, bus.ready);
      end
      if (i == 20) drive(1'b1, 4'hF, 32'h20, 32'hDEADBEEF);
      else drive(1'($urandom_range(0, 1)), 4'h0, {20'h0, 10'($urandom), 2'b00}, 32'h0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    drive(1'b0, 4'h0, 32'h0, 32'h0);
    wait_ready(n);
    total++; if (n !== 1024) begin bad++; $display("FAIL reclear_len: got %0d want 1024", n); end
    model_ready = 1'b1;
    for (int i = 0; i <= 2; i++) begin
      @(negedge clk);
      if (sb_q.size() != 0) dm_held = sb_q.pop_front();
      total++;
      if (bus.dm !== dm_held) begin bad++; $display("FAIL reclr_rd[%0d]: got %h want %h", i, bus.dm, dm_held); end
      if (i < 2) drive(1'b1, 4'h0, 32'(32 + 4 * i), 32'h0);
      else drive(1'b0, 4'h0, 32'h0, 32'h0);
    end
  endtask

  initial begin
    rst_n     = 1'b1;
    bus.dce   = 1'b0;
    bus.we    = 4'h0;
    bus.daddr = 32'h0;
    bus.din   = 32'h0;
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_back_to_back();
    test_bounds();
    test_reset_mid_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
